// File: rtl/dcsk_pkg.sv
// Shared DCSK definitions: spreading-factor IDs, frame constants and receiver states.
// Common to the transmitter and receiver so both ends agree on the chip/frame layout.
package dcsk_pkg;

  localparam int MSG_W  = 32;
  localparam int MAX_SF = 64;

  typedef enum logic [1:0] {SF8, SF16, SF32, SF64} sf_id_e;

  typedef enum logic [1:0] {IDLE, REF, DATA} rx_state_e;

  function automatic logic [6:0] sf_len(sf_id_e id);
    return 7'd8 << id;
  endfunction

endpackage

// File: rtl/dcsk_rx_if.sv
// Chip-stream input and decoded-message output bundle of the DCSK receiver.
// The slave modport is the receiver side; the master modport is the chip source and sink.
interface dcsk_rx_if #(parameter int MSG_W = 32);
  logic             i_rx;
  logic [1:0]       i_sf;
  logic [MSG_W-1:0] o_msg;
  logic             o_valid;
  logic             o_busy;
  logic [6:0]       o_corr;

  modport master (output i_rx, i_sf, input o_msg, o_valid, o_busy, o_corr);
  modport slave  (input i_rx, i_sf, output o_msg, o_valid, o_busy, o_corr);
endinterface

// File: rtl/dcsk_correlator.sv
// Reference-chip buffer plus running match counter; one chip per clock, no backpressure.
// hit is combinational so the owner can see the count including the current chip.
module dcsk_correlator #(
  parameter int MAX_SF = dcsk_pkg::MAX_SF
) (
  input  logic                       i_clk,
  input  logic                       i_arst,
  input  logic                       wr,
  input  logic                       cmp,
  input  logic                       clr,
  input  logic                       din,
  input  dcsk_pkg::sf_id_e           sf,
  output logic [$clog2(MAX_SF+1)-1:0] match_cnt,
  output logic                       hit,
  output logic                       last
);
  import dcsk_pkg::*;

  localparam int IW = $clog2(MAX_SF);
  localparam int CW = $clog2(MAX_SF + 1);

  logic [MAX_SF-1:0] ref_buf;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     len;

  assign len  = CW'(sf_len(sf));
  assign last = (CW'(idx) == len - CW'(1));
  assign hit  = (din == ref_buf[idx]);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      ref_buf   <= '0;
      idx       <= '0;
      match_cnt <= '0;
    end else if (clr) begin
      idx       <= '0;
      match_cnt <= '0;
    end else if (wr) begin
      ref_buf[idx] <= din;
      if (last) begin
        idx       <= '0;
        match_cnt <= '0;
      end else begin
        idx <= idx + IW'(1);
      end
    end else if (cmp) begin
      // Saturation is unnecessary: at most SF hits per bit and CW holds MAX_SF.
      match_cnt <= match_cnt + CW'(hit);
      idx       <= last ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/dcsk_rx.sv
// DCSK receiver: start-chip detect, per-bit reference/data correlation, 32-bit reassembly.
// o_msg/o_valid update on the edge sampling the last data chip; no backpressure (free-running chips).
module dcsk_rx #(
  parameter int MSG_W  = dcsk_pkg::MSG_W,
  parameter int MAX_SF = dcsk_pkg::MAX_SF
) (
  input logic      i_clk,
  input logic      i_arst,
  dcsk_rx_if.slave bus
);
  import dcsk_pkg::*;

  localparam int BW = $clog2(MSG_W);
  localparam int CW = $clog2(MAX_SF + 1);

  rx_state_e        state_q, state_d;
  sf_id_e           sf_q;
  logic [BW-1:0]    bit_cnt;
  logic [MSG_W-1:0] shreg, shreg_nxt, msg_q;
  logic [CW-1:0]    match_cnt, count, half, corr_q;
  logic             wr, cmp, clr, bit_end, done, hit, last, bit_dec, valid_q;

  dcsk_correlator #(.MAX_SF(MAX_SF)) u_corr (
    .i_clk     (i_clk),
    .i_arst    (i_arst),
    .wr        (wr),
    .cmp       (cmp),
    .clr       (clr),
    .din       (bus.i_rx),
    .sf        (sf_q),
    .match_cnt (match_cnt),
    .hit       (hit),
    .last      (last)
  );

  // Decision uses the count including the chip being sampled; a tie decodes as 0.
  assign count     = match_cnt + CW'(hit);
  assign half      = CW'(sf_len(sf_q)) >> 1;
  assign bit_dec   = (count > half);
  assign shreg_nxt = {shreg[MSG_W-2:0], bit_dec};

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    cmp     = 1'b0;
    clr     = 1'b0;
    bit_end = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_rx) begin
          clr     = 1'b1;
          state_d = REF;
        end
      end
      REF: begin
        wr = 1'b1;
        if (last) state_d = DATA;
      end
      DATA: begin
        cmp = 1'b1;
        if (last) begin
          bit_end = 1'b1;
          if (bit_cnt == BW'(MSG_W - 1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = REF;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      sf_q    <= SF8;
      bit_cnt <= '0;
      shreg   <= '0;
      msg_q   <= '0;
      corr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= done;
      if (clr) begin
        sf_q    <= sf_id_e'(bus.i_sf);
        bit_cnt <= '0;
      end
      if (bit_end) begin
        shreg  <= shreg_nxt;
        corr_q <= count;
        if (done) msg_q   <= shreg_nxt;
        else      bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  assign bus.o_msg   = msg_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_corr  = 7'(corr_q);

endmodule

// File: tb/tb_dcsk_rx.sv
// Directed + randomized bench for dcsk_rx: a chip-level transmitter model builds each frame
// and predicts o_corr per bit and o_msg/o_valid timing, checked by a negedge scoreboard.
module tb_dcsk_rx;
  import dcsk_pkg::*;

  logic i_clk  = 1'b0;
  logic i_arst = 1'b0;

  dcsk_rx_if #(.MSG_W(32)) bus ();

  dcsk_rx #(.MSG_W(32), .MAX_SF(64)) dut (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  int          vcount = 0;
  logic [31:0] last_msg = '0;

  int unsigned ev_cyc[$];
  logic [31:0] ev_msg[$];
  int unsigned ec_cyc[$];
  int          ec_val[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare against model expectations keyed by the clock edge they belong to.
  always @(negedge i_clk) begin
    if (!i_arst) begin
      if (ec_cyc.size() > 0 && ec_cyc[0] == cyc) begin
        check("corr", 64'(bus.o_corr), 64'(ec_val[0]));
        void'(ec_cyc.pop_front());
        void'(ec_val.pop_front());
      end
      if (bus.o_valid === 1'b1) begin
        vcount++;
        last_msg = bus.o_msg;
      end
      if (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
        check("valid_pulse", 64'(bus.o_valid), 64'(1));
        check("msg", 64'(bus.o_msg), 64'(ev_msg[0]));
        check("busy_at_valid", 64'(bus.o_busy), 64'(0));
        void'(ev_cyc.pop_front());
        void'(ev_msg.pop_front());
      end else if (bus.o_valid === 1'b1) begin
        check("valid_cycle", 64'(cyc), (ev_cyc.size() > 0) ? 64'(ev_cyc[0]) : 64'hFFFF_FFFF);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      bus.i_rx = 1'b0;
    end
  endtask

  // Builds one frame from the chip rules, queues expectations, drives chips 0..stop_at-1.
  task automatic send_frame(input logic [31:0] msg, input logic [1:0] sf, input int nflip,
                            input int stop_at, input bit toggle_sf, output logic [31:0] exp_msg);
    int          n;
    int          cnt;
    int unsigned s;
    logic        chips[$];
    logic        r, d;
    n       = 8 << sf;
    exp_msg = '0;
    @(negedge i_clk);
    s = cyc + 1;
    chips.push_back(1'b1);
    for (int k = 0; k < 32; k++) begin
      logic refs[$];
      cnt = 0;
      for (int j = 0; j < n; j++) begin
        r = 1'($urandom);
        refs.push_back(r);
        chips.push_back(r);
      end
      for (int j = 0; j < n; j++) begin
        d = msg[31-k] ? refs[j] : ~refs[j];
        if (k == 0 && j < nflip) d = ~d;
        if (d == refs[j]) cnt++;
        chips.push_back(d);
      end
      exp_msg = {exp_msg[30:0], (2 * cnt > n)};
      if (chips.size() - 1 < stop_at) begin
        ec_cyc.push_back(s + chips.size() - 1);
        ec_val.push_back(cnt);
      end
    end
    if (chips.size() <= stop_at) begin
      ev_cyc.push_back(s + chips.size() - 1);
      ev_msg.push_back(exp_msg);
    end
    for (int i = 0; i < chips.size() && i < stop_at; i++) begin
      if (i > 0) @(negedge i_clk);
      bus.i_rx = chips[i];
      bus.i_sf = (i == 0 || !toggle_sf) ? sf : 2'($urandom);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] em, em2;
    int          frames;
    int          vsave;
    frames   = 0;
    bus.i_rx = 1'b0;
    bus.i_sf = 2'b00;

    #2 i_arst = 1'b1;
    #1;
    check("rst_msg",   64'(bus.o_msg),   64'(0));
    check("rst_valid", 64'(bus.o_valid), 64'(0));
    check("rst_busy",  64'(bus.o_busy),  64'(0));
    check("rst_corr",  64'(bus.o_corr),  64'(0));
    repeat (2) @(negedge i_clk);
    i_arst = 1'b0;
    idle(3);

    // SF8 loopback, then SF64 with one and zero bits.
    send_frame(32'hA5A5_F00F, 2'b00, 0, 1 << 30, 1'b0, em); frames++;
    idle(4);
    check("sf8_model", 64'(em), 64'hA5A5_F00F);
    send_frame(32'h8000_0001, 2'b11, 0, 1 << 30, 1'b0, em); frames++;
    idle(4);
    check("sf64_msg", 64'(last_msg), 64'h8000_0001);

    // Chip errors on the first-sent bit: 5 matches still a 1, a 4/4 tie becomes 0.
    send_frame(32'hFFFF_FFFF, 2'b00, 3, 1 << 30, 1'b0, em); frames++;
    idle(4);
    check("flip3_msg", 64'(last_msg), 64'hFFFF_FFFF);
    send_frame(32'hFFFF_FFFF, 2'b00, 4, 1 << 30, 1'b0, em); frames++;
    idle(4);
    check("flip4_tie_msg", 64'(last_msg), 64'h7FFF_FFFF);

    // Back-to-back: second start chip immediately follows the first frame's last chip.
    vsave = vcount;
    send_frame(32'h1234_5678, 2'b01, 0, 1 << 30, 1'b0, em);  frames++;
    send_frame(32'hDEAD_BEEF, 2'b00, 0, 1 << 30, 1'b0, em2); frames++;
    idle(4);
    check("b2b_pulses", 64'(vcount - vsave), 64'(2));
    check("b2b_last", 64'(last_msg), 64'hDEAD_BEEF);

    // Reset at chip 200 of an SF8 frame.
    vsave = vcount;
    send_frame(32'hCAFE_0123, 2'b00, 0, 200, 1'b0, em);
    @(negedge i_clk);
    check("busy_mid", 64'(bus.o_busy), 64'(1));
    i_arst   = 1'b1;
    bus.i_rx = 1'b0;
    ev_cyc.delete(); ev_msg.delete(); ec_cyc.delete(); ec_val.delete();
    #1;
    check("abort_msg",  64'(bus.o_msg),  64'(0));
    check("abort_busy", 64'(bus.o_busy), 64'(0));
    check("abort_corr", 64'(bus.o_corr), 64'(0));
    repeat (3) @(negedge i_clk);
    i_arst = 1'b0;
    idle(3);
    check("abort_no_valid", 64'(vcount - vsave), 64'(0));
    send_frame(32'h0F1E_2D3C, 2'b10, 0, 1 << 30, 1'b0, em); frames++;
    idle(4);
    check("post_reset_msg", 64'(last_msg), 64'h0F1E_2D3C);

    // Long idle line, then a frame with i_sf wandering after the start chip.
    vsave = vcount;
    idle(1000);
    check("idle_busy", 64'(bus.o_busy), 64'(0));
    check("idle_no_valid", 64'(vcount - vsave), 64'(0));
    send_frame(32'h5A5A_3C3C, 2'b01, 0, 1 << 30, 1'b1, em); frames++;
    idle(4);
    check("sf_toggle_msg", 64'(last_msg), 64'h5A5A_3C3C);

    // Randomized frames with random SF and random chip errors on the first bit.
    for (int t = 0; t < 4; t++) begin
      send_frame($urandom, 2'($urandom_range(0, 2)), $urandom_range(0, 8), 1 << 30, 1'b0, em);
      frames++;
      idle($urandom_range(0, 3));
    end
    idle(6);

    check("pending_valid", 64'(ev_cyc.size()), 64'(0));
    check("valid_count", 64'(vcount), 64'(frames));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
